// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial add/subtract datapath:
// controller state encoding and operation select codes.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/full_add_sub_cell.sv
// Combinational 1-bit add/subtract cell; cout is the carry for add and
// the borrow for subtract.
module full_add_sub_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic select,
  output logic s,
  output logic cout
);

  assign s = a ^ b ^ cin;

  // Borrow is produced when b (plus incoming borrow) exceeds a at this bit.
  assign cout = (select == SEL_SUB) ? ((~a & b) | (cin & ~(a ^ b)))
                                    : ((a & b) | (cin & (a | b)));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one 1-bit cell, LSB first, with a
// start/done handshake. Result and flags update only on completion.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             cy;
  logic             op_sel;
  logic             a_msb;
  logic             b_msb;
  logic             cell_s;
  logic             cell_cout;
  logic             ovf_next;

  full_add_sub_cell u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (cy),
    .select (op_sel),
    .s      (cell_s),
    .cout   (cell_cout)
  );

  // Evaluated on the final bit-cycle, where cell_s is the result MSB.
  assign ovf_next = (op_sel == SEL_SUB)
                  ? ((a_msb != b_msb) && (cell_s != a_msb))
                  : ((a_msb == b_msb) && (cell_s != a_msb));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain the shift registers in one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      cy       <= 1'b0;
      op_sel   <= SEL_ADD;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            op_sel  <= select;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            bit_cnt <= '0;
            cy      <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          acc     <= {cell_s, acc[WIDTH-1:1]};
          cy      <= cell_cout;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // Outputs take the completed word, including this cycle's MSB.
            result   <= {cell_s, acc[WIDTH-1:1]};
            c_out    <= cell_cout;
            overflow <= ovf_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: an arithmetic reference model with a
// per-cycle compare, plus directed vectors with hand-computed expectations.
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             select;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .select   (select),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for one operation.
  function automatic void ref_op(input logic sel, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, output logic [WIDTH-1:0] r,
                                 output logic c, output logic v);
    int sx, sy, sr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sel == 1'b0) begin
      {c, r} = {1'b0, x} + {1'b0, y};
      sr = sx + sy;
    end else begin
      r  = x - y;
      c  = (x < y);
      sr = sx - sy;
    end
    v = (sr > (2 ** (WIDTH - 1)) - 1) || (sr < -(2 ** (WIDTH - 1)));
  endfunction

  // Timing model: m_k counts cycles since accept (0 = idle).
  int               m_k = 0;
  logic [WIDTH-1:0] m_res = '0;
  logic [WIDTH-1:0] p_res = '0;
  logic             m_c = 1'b0, m_v = 1'b0, p_c = 1'b0, p_v = 1'b0;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0;
      m_res = '0;
      m_c = 1'b0;
      m_v = 1'b0;
    end else if (m_k == WIDTH + 1) begin
      m_k = 0;
    end else if (m_k > 0) begin
      m_k++;
      if (m_k == WIDTH + 1) begin
        m_res = p_res;
        m_c   = p_c;
        m_v   = p_v;
      end
    end else if (start) begin
      m_k = 1;
      ref_op(select, a, b, p_res, p_c, p_v);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, (m_k >= 1 && m_k <= WIDTH));
      check("model_done", done, (m_k == WIDTH + 1));
      check("model_result", result, m_res);
      check("model_c_out", c_out, m_c);
      check("model_overflow", overflow, m_v);
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input logic sel, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                        input string name);
    int cyc;
    start = 1'b1; select = sel; a = x; b = y;
    @(negedge clk);
    start = 1'b0; select = ~sel; a = ~x; b = ~y;
    cyc = 1;
    check({name, "_busy_c1"}, busy, 1'b1);
    while (!done && cyc < 4 * WIDTH) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, WIDTH + 1);
    check({name, "_result"}, result, er);
    check({name, "_c_out"}, c_out, ec);
    check({name, "_ovf"}, overflow, ev);
    @(negedge clk);
    check({name, "_idle_after"}, busy | done, 1'b0);
  endtask

  initial begin
    int cyc, seen, ops, last;
    reset = 1'b1; start = 1'b0; select = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {c_out, overflow}, 2'b00);
    reset = 1'b0;

    run_op(1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, "add_3c_05");
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, "sub_05_07");
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");

    // A second start during RUN is ignored and never queued.
    start = 1'b1; select = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; select = 1'b1; a = 8'h99; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    cyc = 4;
    while (!done && cyc < 4 * WIDTH) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_latency", cyc, WIDTH + 1);
    check("ign_result", result, 8'h46);
    check("ign_flags", {c_out, overflow}, 2'b00);
    @(negedge clk);
    check("ign_no_requeue", busy, 1'b0);

    // Reset mid-operation discards it without a done pulse.
    start = 1'b1; select = 1'b0; a = 8'h55; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_flags", {c_out, overflow}, 2'b00);
    seen = 0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("mid_rst_no_done", seen, 0);
    run_op(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, "add_10_20");

    // Back-to-back with start held high and random operands every cycle.
    start = 1'b1;
    ops = 0; last = -1; cyc = 0;
    while (ops < 1000 && cyc < 1000 * (WIDTH + 2) + 100) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      select = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0) check("b2b_period", cyc - last, WIDTH + 2);
        last = cyc;
        ops++;
      end
    end
    start = 1'b0;
    check("b2b_ops", ops, 1000);
    repeat (WIDTH + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial, multi-cycle N-bit adder/subtractor built around a single 1-bit add/subtract cell.
- Registered carry/borrow is fed back each cycle, processing LSB first.
- Trades latency (WIDTH cycles) for area.
- Sits behind a start/done handshake.
- Used wherever a wide add/sub is needed but one-bit-cell area is the budget.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; samples a, b, select when accepted
- select  input  1  0 = add (a+b), 1 = subtract (a-b)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  WIDTH  sum or difference (mod 2^WIDTH)
- c_out  output  1  final carry-out (add) or borrow-out (sub)
- overflow  output  1  two's-complement signed overflow of the operation

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset (synchronous, any state, including mid-operation):
  - FSM goes to IDLE; busy=0, done=0, result=0, c_out=0, overflow=0.
  - Internal shift registers, bit counter and carry flop are cleared.
  - Any operation in flight is discarded, with no done pulse.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 latches a, b, select into shift registers; bit counter=0; carry flop=0 (add) or 0 (borrow, sub); go to RUN. busy rises the cycle after start.
  - RUN: each cycle, the cell computes s = a0^b0^cy.
    - Add: cy' = a0&b0 | cy&(a0|b0).
    - Sub: cy' = ~a0&b0 | cy&~(a0^b0).
    - s is shifted into the result MSB. The A/B registers shift right. cy <= cy'. The counter increments.
    - After WIDTH bit-cycles, go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0. Always returns to IDLE next cycle.
- Timing:
  - Latency from the accepting start edge to done high is WIDTH+1 cycles.
  - Throughput is one operation per WIDTH+2 cycles.
- start handling:
  - start is ignored in RUN and DONE; no queuing and no error.
  - start must be re-asserted in IDLE.
- Operand capture:
  - Operands are captured only at accept.
  - Changes on a/b/select while busy have no effect.
- Output hold:
  - result, c_out and overflow hold their last values from DONE until the next operation completes.
  - They do not change during RUN. The shifting happens in an internal register, copied to the outputs at the RUN→DONE transition.
- c_out:
  - Add: carry out of bit WIDTH-1.
  - Sub: borrow out, i.e. 1 iff a < b unsigned.
- overflow:
  - Add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - Sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - The implementation keeps the captured operand MSBs for this check.
- Wrap-around: the result is modulo 2^WIDTH; there is no saturation.
- Bit counter is $clog2(WIDTH+1) bits wide and must not wrap before reaching WIDTH.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SEL_ADD=1'b0 and SEL_SUB=1'b1 constants.
- One sub-module, full_add_sub_cell: combinational 1-bit cell.
  - Inputs: a, b, cin, select.
  - Outputs: s, cout (carry or borrow per the equations above).
  - Instantiated once.
- Top holds the FSM, shift registers, counter and flags.

Test Plan:
1. WIDTH=8, add 0x3C+0x05 → done at cycle 9 after accept; result=0x41, c_out=0, overflow=0; busy high for cycles 1..8.
2. Add 0xFF+0x01 → result=0x00, c_out=1, overflow=0. Add 0x7F+0x01 → result=0x80, c_out=0, overflow=1.
3. Sub 0x05-0x07 → result=0xFE, c_out(borrow)=1, overflow=0. Sub 0x80-0x01 → result=0x7F, c_out=0, overflow=1.
4. Pulse start again during RUN with different operands → ignored; original result is delivered; the second start is accepted only after returning to IDLE.
5. Assert reset at bit-cycle 4 of an operation → next cycle busy=0, all outputs 0, no done pulse. A fresh start then completes correctly, e.g. 0x10+0x20=0x30.
6. Back-to-back: start held high continuously → operations accepted every WIDTH+2 cycles. Random a/b/select vs reference model: 1000 operations, all match.
